// File: rtl/irq_capture_4ch_if.sv
// +--------------------------------------------------------------------------+
// | irq_capture_4ch_if : request/dispatch bus of the 4-channel IRQ capture   |
// | Revision 1.0 -- optional lost-event ports under IRQ_LOST_TRACK_EN        |
// +--------------------------------------------------------------------------+
`default_nettype none

interface irq_capture_4ch_if;
  logic [3:0] req;
  logic [3:0] mask;
  logic       idx_valid;
  logic [1:0] idx;
  logic       idx_ready;
  logic [3:0] pending;
`ifdef IRQ_LOST_TRACK_EN
  logic [3:0] lost;
  logic [3:0] lost_clr;
`endif

  // Driven by the request source / index consumer.
  modport master (
    output req, mask, idx_ready,
`ifdef IRQ_LOST_TRACK_EN
    output lost_clr,
    input  lost,
`endif
    input  idx_valid, idx, pending
  );

  // Taken by the capture block itself.
  modport slave (
    input  req, mask, idx_ready,
`ifdef IRQ_LOST_TRACK_EN
    input  lost_clr,
    output lost,
`endif
    output idx_valid, idx, pending
  );
endinterface

`default_nettype wire

// File: rtl/irq_capture_4ch.sv
// +--------------------------------------------------------------------------+
// | irq_capture_4ch : rising-edge IRQ capture, fixed-priority dispatch (3>0) |
// | Revision 1.0 -- lost-event tracking built only with IRQ_LOST_TRACK_EN    |
// +--------------------------------------------------------------------------+
`default_nettype none

module irq_capture_4ch (
  input  wire logic          clk,
  input  wire logic          rst_n,
  irq_capture_4ch_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] req_prev_q;
  logic [3:0] pending_q, pending_d;
  logic [1:0] idx_q, idx_d;

  logic [3:0] req_edge;
  logic [3:0] eligible;
  logic [1:0] winner;
  logic       dispatch;
  logic [3:0] pending_clr;

  assign req_edge = bus.req & ~req_prev_q;
  // Selection looks at registered pending only, so a same-cycle edge waits a cycle.
  assign eligible = pending_q & ~bus.mask;

  always_comb begin
    winner = 2'd0;
    if (eligible[3])      winner = 2'd3;
    else if (eligible[2]) winner = 2'd2;
    else if (eligible[1]) winner = 2'd1;
    else                  winner = 2'd0;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dispatch    = 1'b0;
    pending_clr = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          dispatch = 1'b1;
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.idx_ready) begin
          if (|eligible) dispatch = 1'b1;
          else           state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (dispatch) begin
      idx_d       = winner;
      pending_clr = 4'b0001 << winner;
    end
    // A new edge overrides the dispatch clear of the same bit.
    pending_d = (pending_q & ~pending_clr) | req_edge;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      req_prev_q <= 4'b0000;
      pending_q  <= 4'b0000;
      idx_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      req_prev_q <= bus.req;
      pending_q  <= pending_d;
      idx_q      <= idx_d;
    end
  end

  assign bus.idx_valid = (state_q == ST_PRESENT);
  assign bus.idx       = idx_q;
  assign bus.pending   = pending_q;

`ifdef IRQ_LOST_TRACK_EN
  logic [3:0] lost_q, lost_d;

  // An edge merging into a still-pending bit is a lost event; a bit being
  // dispatched in the same cycle is not, since the new edge re-arms it.
  always_comb begin
    lost_d = (lost_q & ~bus.lost_clr) | (req_edge & pending_q & ~pending_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_q <= 4'b0000;
    else        lost_q <= lost_d;
  end

  assign bus.lost = lost_q;
`endif

endmodule

`default_nettype wire
